multi_cycle_control: RTL and testbench



---
 rtl/multi_cycle_control.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control FSM: sequences each instruction over 2-5 cycles and drives ALU, register-file, memory and PC controls.
// Optional build macro ILLEGAL_TRAP_EN: unlisted opcodes trap (sticky illegal_op + halt) instead of executing as a NOP.
module multi_cycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcB,
    output logic       alusrca,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc,
    output logic [2:0] state_out,
    output logic       halted,
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_B  = 3'b101,
        S_EXE_R  = 3'b110,
        S_WB_R   = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t     state, state_next;
    logic       halted_q, halted_next;
    logic [2:0] dec_aluop;
    logic       dec_srcb, dec_srca, dec_ext, is_rfmt, is_alu;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_q, illegal_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IF;
            halted_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            halted_q <= halted_next;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_next;
`endif
        end
    end

    // Opcode decode; is_alu marks instructions that go through EXE_R/WB_R.
    always_comb begin
        dec_aluop = 3'b000;
        dec_srcb  = 1'b0;
        dec_srca  = 1'b0;
        dec_ext   = 1'b0;
        is_rfmt   = 1'b0;
        is_alu    = 1'b0;
        case (opcode)
            OP_ADD:   begin is_rfmt = 1'b1; is_alu = 1'b1; end
            OP_SUB:   begin dec_aluop = 3'b001; is_rfmt = 1'b1; is_alu = 1'b1; end
            OP_ADDIU: begin dec_srcb = 1'b1; dec_ext = 1'b1; is_alu = 1'b1; end
            OP_ANDI:  begin dec_aluop = 3'b100; dec_srcb = 1'b1; is_alu = 1'b1; end
            OP_AND:   begin dec_aluop = 3'b100; is_rfmt = 1'b1; is_alu = 1'b1; end
            OP_ORI:   begin dec_aluop = 3'b011; dec_srcb = 1'b1; is_alu = 1'b1; end
            OP_OR:    begin dec_aluop = 3'b011; is_rfmt = 1'b1; is_alu = 1'b1; end
            OP_SLL:   begin dec_aluop = 3'b010; dec_srca = 1'b1; is_rfmt = 1'b1; is_alu = 1'b1; end
            OP_SLTI:  begin dec_aluop = 3'b110; dec_srcb = 1'b1; dec_ext = 1'b1; is_alu = 1'b1; end
            OP_SW, OP_LW:   begin dec_srcb = 1'b1; dec_ext = 1'b1; end
            OP_BEQ, OP_BNE: begin dec_aluop = 3'b001; dec_ext = 1'b1; end
            default: ;
        endcase
    end

    // Next state and outputs; ALU controls stay valid from ID until the instruction retires.
    always_comb begin
        state_next  = state;
        halted_next = halted_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_next = illegal_q;
`endif
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcB   = 1'b0;
        alusrca   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;
        if (state != S_IF) begin
            ALUOp   = dec_aluop;
            ALUSrcB = dec_srcb;
            alusrca = dec_srca;
            ExtSel  = dec_ext;
        end
        case (state)
            S_IF: begin
                InsMemRW   = 1'b1;
                IRWre      = 1'b1;
                state_next = S_ID;
            end
            S_ID: begin
                if (halted_q) begin
                    state_next = S_ID;
                end else begin
                    case (opcode)
                        OP_HALT: begin
                            halted_next = 1'b1;
                            state_next  = S_ID;
                        end
                        OP_J: begin
                            PCWre = 1'b1; PCSrc = 2'b11; state_next = S_IF;
                        end
                        OP_JAL: begin
                            PCWre = 1'b1; PCSrc = 2'b11; RegWre = 1'b1;
                            RegDst = 2'b10; WrRegDSrc = 1'b1; state_next = S_IF;
                        end
                        OP_JR: begin
                            PCWre = 1'b1; PCSrc = 2'b10; state_next = S_IF;
                        end
                        OP_BEQ, OP_BNE: state_next = S_EXE_B;
                        OP_SW, OP_LW:   state_next = S_EXE_LS;
                        default: begin
                            if (is_alu) begin
                                state_next = S_EXE_R;
                            end else begin
`ifdef ILLEGAL_TRAP_EN
                                illegal_next = 1'b1;
                                halted_next  = 1'b1;
                                state_next   = S_ID;
`else
                                PCWre      = 1'b1;
                                state_next = S_IF;
`endif
                            end
                        end
                    endcase
                end
            end
            S_EXE_R:  state_next = S_WB_R;
            S_WB_R: begin
                RegWre     = 1'b1;
                PCWre      = 1'b1;
                RegDst     = is_rfmt ? 2'b01 : 2'b00;
                state_next = S_IF;
            end
            S_EXE_B: begin
                PCWre      = 1'b1;
                PCSrc      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero) ? 2'b01 : 2'b00;
                state_next = S_IF;
            end
            S_EXE_LS: state_next = S_MEM;
            S_MEM: begin
                if (opcode == OP_LW) begin
                    mRD        = 1'b1;
                    state_next = S_WB_L;
                end else begin
                    mWR        = 1'b1;
                    PCWre      = 1'b1;
                    state_next = S_IF;
                end
            end
            S_WB_L: begin
                mRD        = 1'b1;
                DBDataSrc  = 1'b1;
                RegWre     = 1'b1;
                PCWre      = 1'b1;
                state_next = S_IF;
            end
            default: state_next = S_IF;
        endcase
        // An instruction aborted by reset must not write or fetch anything.
        if (reset) begin
            PCWre    = 1'b0;
            IRWre    = 1'b0;
            InsMemRW = 1'b0;
            RegWre   = 1'b0;
            mRD      = 1'b0;
            mWR      = 1'b0;
        end
    end

    assign state_out = state;
    assign halted    = halted_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: a per-instruction reference model queues the expected
// output vector of every cycle, and a negedge monitor compares the DUT against it.
module tb_multi_cycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, insmem, srcb, srca;
        logic [2:0] aluop;
        logic       ext, regwre;
        logic [1:0] regdst;
        logic       wrsrc, dbsrc, mrd, mwr;
        logic [1:0] pcsrc;
        logic       halted, illegal;
    } out_t;

    localparam int CL_ILL = 0, CL_ALU = 1, CL_LW = 2, CL_SW = 3, CL_BR = 4;
    localparam int CL_J = 5, CL_JAL = 6, CL_JR = 7, CL_HALT = 8;

    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] opcode;
    logic       PCWre, IRWre, InsMemRW, ALUSrcB, alusrca, ExtSel, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR, halted, illegal_op;
    logic [2:0] ALUOp, state_out;
    logic [1:0] RegDst, PCSrc;

    out_t exp_q[$];
    out_t seq_q[$];
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    multi_cycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcB(ALUSrcB),
        .alusrca(alusrca), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD),
        .mWR(mWR), .PCSrc(PCSrc), .state_out(state_out), .halted(halted),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Opcode table: ALU controls and instruction class.
    function automatic void alu_info(input logic [5:0] op, output logic [2:0] aop, output logic sb,
                                     output logic sa, output logic ext, output logic rf, output int cls);
        aop = 3'b000; sb = 1'b0; sa = 1'b0; ext = 1'b0; rf = 1'b0; cls = CL_ILL;
        case (op)
            6'b000000: begin rf = 1; cls = CL_ALU; end
            6'b000001: begin aop = 3'b001; rf = 1; cls = CL_ALU; end
            6'b000010: begin sb = 1; ext = 1; cls = CL_ALU; end
            6'b010000: begin aop = 3'b100; sb = 1; cls = CL_ALU; end
            6'b010001: begin aop = 3'b100; rf = 1; cls = CL_ALU; end
            6'b010010: begin aop = 3'b011; sb = 1; cls = CL_ALU; end
            6'b010011: begin aop = 3'b011; rf = 1; cls = CL_ALU; end
            6'b011000: begin aop = 3'b010; sa = 1; rf = 1; cls = CL_ALU; end
            6'b100110: begin aop = 3'b110; sb = 1; ext = 1; cls = CL_ALU; end
            6'b110000: begin sb = 1; ext = 1; cls = CL_SW; end
            6'b110001: begin sb = 1; ext = 1; cls = CL_LW; end
            6'b110100, 6'b110101: begin aop = 3'b001; ext = 1; cls = CL_BR; end
            6'b111000: cls = CL_J;
            6'b111001: cls = CL_JR;
            6'b111010: cls = CL_JAL;
            6'b111111: cls = CL_HALT;
            default: cls = CL_ILL;
        endcase
    endfunction

    function automatic out_t mask_enables(input out_t e);
        out_t m = e;
        m.pcwre = 0; m.irwre = 0; m.insmem = 0; m.regwre = 0; m.mrd = 0; m.mwr = 0;
        return m;
    endfunction

    // Builds the per-cycle expected outputs of one instruction into seq_q.
    task automatic modelInstr(input logic [5:0] op, input logic z);
        out_t e, base;
        logic [2:0] aop;
        logic sb, sa, ext, rf;
        int cls;
        alu_info(op, aop, sb, sa, ext, rf, cls);
        seq_q.delete();
        e = '0; e.irwre = 1; e.insmem = 1;
        seq_q.push_back(e);
        base = '0; base.aluop = aop; base.srcb = sb; base.srca = sa; base.ext = ext;
        e = base; e.st = 3'd1;
        case (cls)
            CL_J:    begin e.pcwre = 1; e.pcsrc = 2'b11; seq_q.push_back(e); end
            CL_JAL:  begin
                e.pcwre = 1; e.pcsrc = 2'b11; e.regwre = 1; e.regdst = 2'b10; e.wrsrc = 1;
                seq_q.push_back(e);
            end
            CL_JR:   begin e.pcwre = 1; e.pcsrc = 2'b10; seq_q.push_back(e); end
            CL_HALT: seq_q.push_back(e);
            CL_ILL:  begin
`ifndef ILLEGAL_TRAP_EN
                e.pcwre = 1;
`endif
                seq_q.push_back(e);
            end
            CL_BR: begin
                seq_q.push_back(e);
                e = base; e.st = 3'd5; e.pcwre = 1;
                e.pcsrc = ((op == 6'b110100) ? z : !z) ? 2'b01 : 2'b00;
                seq_q.push_back(e);
            end
            CL_LW: begin
                seq_q.push_back(e);
                e = base; e.st = 3'd2; seq_q.push_back(e);
                e = base; e.st = 3'd3; e.mrd = 1; seq_q.push_back(e);
                e = base; e.st = 3'd4; e.mrd = 1; e.dbsrc = 1; e.regwre = 1; e.pcwre = 1;
                seq_q.push_back(e);
            end
            CL_SW: begin
                seq_q.push_back(e);
                e = base; e.st = 3'd2; seq_q.push_back(e);
                e = base; e.st = 3'd3; e.mwr = 1; e.pcwre = 1; seq_q.push_back(e);
            end
            default: begin
                seq_q.push_back(e);
                e = base; e.st = 3'd6; seq_q.push_back(e);
                e = base; e.st = 3'd7; e.regwre = 1; e.pcwre = 1; e.regdst = rf ? 2'b01 : 2'b00;
                seq_q.push_back(e);
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z);
        int n;
        modelInstr(op, z);
        opcode = op;
        zero   = z;
        n = seq_q.size();
        foreach (seq_q[i]) exp_q.push_back(seq_q[i]);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic holdCycles(input int n, input logic ill);
        out_t e = '0;
        e.st = 3'd1; e.halted = 1; e.illegal = ill;
        repeat (n) exp_q.push_back(e);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetPulse(input out_t during);
        reset = 1'b1;
        exp_q.push_back(mask_enables(during));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkOutput(input out_t act, input out_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL outputs cycle %0d state=%0d: actual=%h expected=%h", cyc, exp.st, act, exp);
    endtask

    always @(negedge clk) begin
        out_t a, e;
        cyc++;
        if (mon_en && exp_q.size() > 0) begin
            a = {state_out, PCWre, IRWre, InsMemRW, ALUSrcB, alusrca, ALUOp, ExtSel, RegWre,
                 RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, halted, illegal_op};
            e = exp_q.pop_front();
            checkOutput(a, e);
        end
    end

    initial begin
        logic [5:0] ops[16];
        logic [5:0] op;
        out_t e;
        ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b010011,
                6'b011000, 6'b100110, 6'b110000, 6'b110001, 6'b110100, 6'b110101,
                6'b111000, 6'b111001, 6'b111010};
        reset = 1'b1; opcode = 6'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        applyStimulus(6'b000000, 1'b0);
        applyStimulus(6'b110001, 1'b0);
        applyStimulus(6'b110100, 1'b1);
        applyStimulus(6'b110100, 1'b0);
        applyStimulus(6'b110101, 1'b0);
        applyStimulus(6'b110101, 1'b1);
        applyStimulus(6'b011000, 1'b0);
        applyStimulus(6'b111010, 1'b0);
        applyStimulus(6'b110000, 1'b1);
        applyStimulus(6'b010010, 1'b0);

        // Reset arriving in WB_R of an add must suppress its writes.
        modelInstr(6'b000000, 1'b0);
        opcode = 6'b000000;
        for (int i = 0; i < 3; i++) exp_q.push_back(seq_q[i]);
        repeat (3) @(posedge clk);
        #1;
        resetPulse(seq_q[3]);
        applyStimulus(6'b000001, 1'b0);

        applyStimulus(6'b111111, 1'b0);
        holdCycles(10, 1'b0);
        e = '0; e.st = 3'd1; e.halted = 1;
        resetPulse(e);
        applyStimulus(6'b000000, 1'b0);

`ifdef ILLEGAL_TRAP_EN
        applyStimulus(6'b101010, 1'b0);
        holdCycles(5, 1'b1);
        e = '0; e.st = 3'd1; e.halted = 1; e.illegal = 1;
        resetPulse(e);
`else
        applyStimulus(6'b101010, 1'b0);
`endif
        applyStimulus(6'b000010, 1'b0);

        for (int k = 0; k < 150; k++) begin
            op = ops[$urandom_range(0, 15)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(0, 62));
            end
`endif
            applyStimulus(op, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("[TB] FAIL scoreboard drain: actual=%0d pending expected=0", exp_q.size());
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
